dot_matrix_scanner: RTL and testbench

//  Consumer side of the 64-bit DotMatrix glyph bus: accepts a 64-bit frame via

---
 rtl/dot_matrix_scanner_pkg.sv | 22 ++
 rtl/dot_matrix_scanner_row_timer.sv | 43 ++++
 rtl/dot_matrix_scanner.sv | 175 +++++++++++++++++
 tb/tb_dot_matrix_scanner.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_matrix_scanner_pkg.sv
// Shared types and helpers for the DotMatrix 8x8 scanner.
// Frame layout: bit 8*r+c is row r (0 = top), column c (0 = left).
package dotmatrix_pkg;

    localparam int NUM_ROWS = 8;
    localparam int ROW_W    = 8;
    localparam int FRAME_W  = 64;

    localparam logic [2:0] LAST_ROW = 3'(NUM_ROWS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

    function automatic logic [ROW_W-1:0] row_slice(input logic [FRAME_W-1:0] frame,
                                                    input logic [2:0]         row);
        return frame[ROW_W*int'(row) +: ROW_W];
    endfunction

endpackage

// File: rtl/dot_matrix_scanner_row_timer.sv
// Row-slot cycle counter for dot_matrix_scanner: blank/row end ticks and PWM phase.
// The pwm port exists only when DIM_PWM_EN is defined.
module row_timer #(
    parameter int ROW_CYCLES   = 1024,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       clear,
`ifdef DIM_PWM_EN
    output logic [3:0] pwm,
`endif
    output logic       blankDone,
    output logic       rowDone
);

    localparam int CNT_W = $clog2(ROW_CYCLES);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] ROW_LAST   = CNT_W'(ROW_CYCLES - 1);

    logic [CNT_W-1:0] count_r;

    // Count through one row slot, wrap at the end, park at zero while cleared.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (count_r == ROW_LAST) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + CNT_W'(1);
        end
    end

    assign blankDone = (count_r == BLANK_LAST);
    assign rowDone   = (count_r == ROW_LAST);

`ifdef DIM_PWM_EN
    assign pwm = count_r[3:0];
`endif

endmodule

// File: rtl/dot_matrix_scanner.sv
// Double-buffered 8x8 LED matrix scanner fed by the 64-bit DotMatrix glyph bus.
// Optional DIM_PWM_EN adds the Brightness port and PWM dimming of the drive phase.
module dot_matrix_scanner
    import dotmatrix_pkg::*;
#(
    parameter int ROW_CYCLES   = 1024,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                Enable,
    input  logic [FRAME_W-1:0]  FrameIn,
    input  logic                FrameValid,
`ifdef DIM_PWM_EN
    input  logic [3:0]          Brightness,
`endif
    output logic                FrameReady,
    output logic [NUM_ROWS-1:0] RowSel,
    output logic [ROW_W-1:0]    ColData,
    output logic                FrameStart
);

    scan_state_t        state_r;
    logic [2:0]         row_r;
    logic [FRAME_W-1:0] active_r;
    logic [FRAME_W-1:0] pending_r;
    logic               pendFull_r;

    logic timerClear_s;
    logic blankDone_s;
    logic rowDone_s;
    logic accept_s;
    logic boundary_s;
    logic pendFullNext_s;
    logic pwmOn_s;

`ifdef DIM_PWM_EN
    logic [3:0] pwm_s;
    logic [3:0] brightness_r;
`endif

    row_timer #(
        .ROW_CYCLES   (ROW_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_row_timer (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .clear     (timerClear_s),
`ifdef DIM_PWM_EN
        .pwm       (pwm_s),
`endif
        .blankDone (blankDone_s),
        .rowDone   (rowDone_s)
    );

    // Handshake, frame-boundary detection and next pending-buffer occupancy.
    always_comb begin
        accept_s     = FrameValid && FrameReady;
        timerClear_s = !Enable || (state_r == IDLE);
        boundary_s   = 1'b0;
        if (Enable) begin
            case (state_r)
                IDLE:    boundary_s = 1'b1;
                BLANK:   boundary_s = 1'b0;
                DRIVE:   boundary_s = rowDone_s && (row_r == LAST_ROW);
                default: boundary_s = 1'b0;
            endcase
        end else begin
            boundary_s = 1'b0;
        end
        // An accept can only coincide with a boundary when pending was empty,
        // so that frame waits for the following boundary.
        if (accept_s) begin
            pendFullNext_s = 1'b1;
        end else if (boundary_s) begin
            pendFullNext_s = 1'b0;
        end else begin
            pendFullNext_s = pendFull_r;
        end
    end

    // Drive-phase gating: PWM duty when dimming is built in, otherwise always on.
    always_comb begin
`ifdef DIM_PWM_EN
        pwmOn_s = (pwm_s < brightness_r);
`else
        pwmOn_s = 1'b1;
`endif
    end

    // Pending/active double buffer; active only changes at a frame boundary.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            pending_r  <= '0;
            active_r   <= '0;
            pendFull_r <= 1'b0;
            FrameReady <= 1'b1;
        end else begin
            if (accept_s) begin
                pending_r <= FrameIn;
            end else begin
                pending_r <= pending_r;
            end
            if (boundary_s && pendFull_r) begin
                active_r <= pending_r;
            end else begin
                active_r <= active_r;
            end
            pendFull_r <= pendFullNext_s;
            FrameReady <= !pendFullNext_s;
        end
    end

    // Scan FSM with registered row/column drive and frame-start pulse.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r      <= IDLE;
            row_r        <= 3'd0;
            RowSel       <= '0;
            ColData      <= '0;
            FrameStart   <= 1'b0;
`ifdef DIM_PWM_EN
            brightness_r <= 4'd0;
`endif
        end else begin
            FrameStart <= boundary_s;
`ifdef DIM_PWM_EN
            if (boundary_s) begin
                brightness_r <= Brightness;
            end else begin
                brightness_r <= brightness_r;
            end
`endif
            if (!Enable) begin
                state_r <= IDLE;
                row_r   <= 3'd0;
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r <= BLANK;
                        row_r   <= 3'd0;
                    end
                    BLANK: begin
                        if (blankDone_s) begin
                            state_r <= DRIVE;
                        end else begin
                            state_r <= BLANK;
                        end
                    end
                    DRIVE: begin
                        if (rowDone_s) begin
                            state_r <= BLANK;
                            row_r   <= row_r + 3'd1;
                        end else begin
                            state_r <= DRIVE;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        row_r   <= 3'd0;
                    end
                endcase
            end
            // Enable gates the drive directly so the display goes dark on the dropping edge.
            if (Enable && (state_r == DRIVE) && pwmOn_s) begin
                RowSel  <= NUM_ROWS'(1'b1) << row_r;
                ColData <= row_slice(active_r, row_r);
            end else begin
                RowSel  <= '0;
                ColData <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dot_matrix_scanner.sv
// Self-checking bench for dot_matrix_scanner (ROW_CYCLES=32, BLANK_CYCLES=4).
module tb_dot_matrix_scanner;

    localparam int ROWC   = 32;
    localparam int BLANKC = 4;
    localparam int FRAMEC = 8 * ROWC;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        Enable;
    logic [63:0] FrameIn;
    logic        FrameValid;
    logic        FrameReady;
    logic [7:0]  RowSel;
    logic [7:0]  ColData;
    logic        FrameStart;
`ifdef DIM_PWM_EN
    logic [3:0]  Brightness;
`endif

    dot_matrix_scanner #(
        .ROW_CYCLES   (ROWC),
        .BLANK_CYCLES (BLANKC)
    ) dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .Enable     (Enable),
        .FrameIn    (FrameIn),
        .FrameValid (FrameValid),
`ifdef DIM_PWM_EN
        .Brightness (Brightness),
`endif
        .FrameReady (FrameReady),
        .RowSel     (RowSel),
        .ColData    (ColData),
        .FrameStart (FrameStart)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    // Scoreboard: frames accepted by the bus wait here until a frame boundary.
    logic [63:0] pendQ[$];
    logic [63:0] expActive = 64'd0;
    int          sIdx = -1;          // cycles since scan start, -1 while parked
    logic        lastAcc = 1'b0;
    int          briLatched = 0;

    typedef struct {
        int         t;
        logic [7:0] rs;
        logic [7:0] cd;
        logic       fs;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at s=%0d: got %0h expected %0h", name, sIdx, act, exp);
        end
    endtask

    // Apply one clock edge to the model, then compare the DUT on the falling edge.
    task automatic cycle();
        int         prevS;
        int         row;
        logic       bnd;
        logic       pwmOk;
        logic [7:0] expRs;
        logic [7:0] expCd;
        lastAcc = FrameValid && (pendQ.size() == 0);
        prevS   = sIdx;
`ifdef DIM_PWM_EN
        pwmOk = ((prevS % 16) < briLatched);
`else
        pwmOk = 1'b1;
`endif
        if (Enable && prevS >= 0 && (prevS % ROWC) >= BLANKC && pwmOk) begin
            row   = (prevS / ROWC) % 8;
            expRs = 8'h01 << row;
            expCd = expActive[8*row +: 8];
        end else begin
            expRs = 8'h00;
            expCd = 8'h00;
        end
        if (!Enable) begin
            sIdx = -1;
            bnd  = 1'b0;
        end else begin
            sIdx = prevS + 1;
            bnd  = ((sIdx % FRAMEC) == 0);
        end
        if (bnd && pendQ.size() > 0) expActive = pendQ.pop_front();
        if (lastAcc) pendQ.push_back(FrameIn);
`ifdef DIM_PWM_EN
        if (bnd) briLatched = int'(Brightness);
`endif
        @(negedge Clock);
        chk("RowSel", RowSel, expRs);
        chk("ColData", ColData, expCd);
        chk("FrameStart", {7'd0, FrameStart}, {7'd0, bnd});
        chk("FrameReady", {7'd0, FrameReady}, {7'd0, (pendQ.size() == 0)});
    endtask

    task automatic runTo(input int target);
        int n = 0;
        while (sIdx < target && n < 4000) begin
            cycle();
            n++;
        end
    endtask

    task automatic driveFrame(input logic [63:0] f);
        int n = 0;
        FrameValid = 1'b1;
        FrameIn    = f;
        lastAcc    = 1'b0;
        while (!lastAcc && n < 2000) begin
            cycle();
            n++;
        end
        FrameValid = 1'b0;
        if (!lastAcc) begin
            checks++;
            errors++;
            $display("FAIL acceptTimeout frame %0h not taken after %0d cycles", f, n);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        logic [63:0] fA;
        logic [63:0] fB;
        logic [63:0] fC;
        int onCount;

        tbl[0]  = '{0,   8'h00, 8'h00, 1'b1};
        tbl[1]  = '{4,   8'h00, 8'h00, 1'b0};
        tbl[2]  = '{5,   8'h01, 8'h01, 1'b0};
        tbl[3]  = '{31,  8'h01, 8'h01, 1'b0};
        tbl[4]  = '{33,  8'h00, 8'h00, 1'b0};
        tbl[5]  = '{37,  8'h02, 8'h02, 1'b0};
        tbl[6]  = '{101, 8'h08, 8'h08, 1'b0};
        tbl[7]  = '{165, 8'h20, 8'h20, 1'b0};
        tbl[8]  = '{255, 8'h80, 8'h80, 1'b0};
        tbl[9]  = '{257, 8'h00, 8'h00, 1'b0};
        tbl[10] = '{261, 8'h01, 8'h01, 1'b0};
        fA = 64'h0123456789ABCDEF;
        fB = 64'hFEDCBA9876543210;
        fC = 64'h55AA33CC0FF01234;

        Reset_n    = 1'b0;
        Enable     = 1'b0;
        FrameValid = 1'b0;
        FrameIn    = 64'd0;
`ifdef DIM_PWM_EN
        Brightness = 4'd15;
`endif
        repeat (3) @(negedge Clock);
        chk("rstRowSel", RowSel, 8'h00);
        chk("rstColData", ColData, 8'h00);
        chk("rstFrameReady", {7'd0, FrameReady}, 8'h01);
        chk("rstFrameStart", {7'd0, FrameStart}, 8'h00);
        Reset_n = 1'b1;
        repeat (5) cycle();

        // Single frame: diagonal glyph, sparse spot checks from a table.
        driveFrame(64'h8040201008040201);
        cycle();
        chk("readyAfterAccept", {7'd0, FrameReady}, 8'h00);
        Enable = 1'b1;
        cycle();
        for (int i = 0; i < 11; i++) begin
            runTo(tbl[i].t);
            chk("tblRowSel", RowSel, tbl[i].rs);
            chk("tblColData", ColData, tbl[i].cd);
            chk("tblFrameStart", {7'd0, FrameStart}, {7'd0, tbl[i].fs});
        end

        // Double buffer: A swaps at 512, B lands mid-row 3, C is back-pressured.
        driveFrame(fA);
        runTo(2 * FRAMEC + 3 * ROWC + 10);
        driveFrame(fB);
        chk("noTearRow3", ColData, fA[31:24]);
        chk("readyAfterB", {7'd0, FrameReady}, 8'h00);
        driveFrame(fC);
        chk("readyAfterC", {7'd0, FrameReady}, 8'h00);
        runTo(3 * FRAMEC + BLANKC + 1);
        chk("bRow0", ColData, fB[7:0]);
        chk("bRow0Sel", RowSel, 8'h01);

        // Enable drop during row 5 drive, then restart with a boundary swap of C.
        runTo(3 * FRAMEC + 5 * ROWC + 10);
        Enable = 1'b0;
        cycle();
        chk("dropRowSel", RowSel, 8'h00);
        chk("dropColData", ColData, 8'h00);
        repeat (3) cycle();
        Enable = 1'b1;
        cycle();
        chk("restartFrameStart", {7'd0, FrameStart}, 8'h01);
        runTo(BLANKC + 1);
        chk("cRow0", ColData, fC[7:0]);

`ifdef DIM_PWM_EN
        // Brightness 4: four lit cycles in each group of sixteen drive cycles.
        Enable = 1'b0;
        cycle();
        Brightness = 4'd4;
        Enable = 1'b1;
        cycle();
        runTo(BLANKC);
        onCount = 0;
        for (int i = 0; i < 16; i++) begin
            cycle();
            if (RowSel != 8'h00) onCount++;
        end
        chk("pwmDuty4", 8'(onCount), 8'd4);
        Enable = 1'b0;
        cycle();
        Brightness = 4'd0;
        Enable = 1'b1;
        cycle();
        onCount = 0;
        for (int i = 0; i < FRAMEC - 1; i++) begin
            cycle();
            if (RowSel != 8'h00) onCount++;
        end
        chk("pwmDark", 8'(onCount), 8'd0);
        Brightness = 4'd15;
`else
        onCount = 0;
`endif

        // Reset in mid-scan with a frame pending: dark at once, buffers cleared.
        driveFrame(64'hFFFFFFFFFFFFFFFF);
        runTo(((sIdx / ROWC) + 1) * ROWC + 10);
        #1;
        Reset_n = 1'b0;
        #1;
        chk("asyncRowSel", RowSel, 8'h00);
        chk("asyncColData", ColData, 8'h00);
        chk("asyncFrameReady", {7'd0, FrameReady}, 8'h01);
        pendQ.delete();
        expActive  = 64'd0;
        sIdx       = -1;
        briLatched = 0;
        Enable     = 1'b0;
        @(negedge Clock);
        Reset_n = 1'b1;
        cycle();
        Enable = 1'b1;
        cycle();
        runTo(ROWC + BLANKC + 4);
        chk("clearedRowSel", RowSel, 8'h02);
        chk("clearedColData", ColData, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
